// File: rtl/spi_flash_arbiter_pkg.sv
// Shared types and constants for the two-master SPI configuration flash arbiter.
package spi_flash_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_HOLDOFF = 2'd2
  } arb_state_t;

  localparam int REQ_DSP = 0;
  localparam int REQ_CPU = 1;

  function automatic logic [1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/spi_flash_arbiter_if.sv
// Requester/flash pin bundle plus arbiter status; slave = arbiter side, master = board side.
interface spi_flash_arbiter_if #(
  parameter int CNT_W = 8
);
  logic [1:0]       req_clk;
  logic [1:0]       req_mosi;
  logic [1:0]       req_cs_INV;
  logic [1:0]       req_miso;
  logic             flash_clk;
  logic             flash_mosi;
  logic             flash_cs_INV;
  logic             flash_miso;
  logic [1:0]       owner;
  logic [1:0]       busy;
  logic [CNT_W-1:0] blocked_cnt;
  logic             wdt_trip;

  modport slave (
    input  req_clk, req_mosi, req_cs_INV, flash_miso,
    output req_miso, flash_clk, flash_mosi, flash_cs_INV,
    output owner, busy, blocked_cnt, wdt_trip
  );

  modport master (
    output req_clk, req_mosi, req_cs_INV, flash_miso,
    input  req_miso, flash_clk, flash_mosi, flash_cs_INV,
    input  owner, busy, blocked_cnt, wdt_trip
  );
endinterface

// File: rtl/spi_flash_arbiter_cs_sync.sv
// Two-flop chip-select synchroniser (resets deasserted) with a one-cycle falling-edge pulse.
module spi_cs_sync (
  input  logic sysclk,
  input  logic reset_INV,
  input  logic cs_raw_INV,
  output logic cs_sync_INV,
  output logic cs_fall
);

  // [0],[1] are the synchroniser stages; [2] is the previous synchronised value for edge detect
  logic [2:0] shift;

  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) shift <= 3'b111;
    else            shift <= {shift[1:0], cs_raw_INV};
  end

  assign cs_sync_INV = shift[1];
  assign cs_fall     = shift[2] & ~shift[1];

endmodule

// File: rtl/spi_flash_arbiter.sv
// Arbitrates the configuration flash between DSP (req 0) and CPU (req 1) SPI masters.
// Optional stuck-owner watchdog enabled by defining SPI_FLASH_ARB_WATCHDOG_EN.
module spi_flash_arbiter
  import spi_flash_arbiter_pkg::*;
#(
  parameter int          HOLDOFF_CYCLES = 4,
  parameter int          CNT_W          = 8,
  parameter logic [23:0] WDT_CYCLES     = 24'd4000000
) (
  input logic           sysclk,
  input logic           reset_INV,
  input logic           enable,
  spi_flash_arbiter_if.slave bus
);

  localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  arb_state_t       state;
  logic [1:0]       owner;
  logic [1:0]       busy;
  logic [CNT_W-1:0] blocked_cnt;
  logic             last_owner;
  logic [HOLD_W-1:0] hold_cnt;
  logic [1:0]       cs_sync_INV;
  logic [1:0]       cs_fall;
  logic             pick;
  logic             owner_release;
  logic [1:0]       blk;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_next;

  for (genvar i = 0; i < 2; i++) begin : g_sync
    spi_cs_sync u_sync (
      .sysclk      (sysclk),
      .reset_INV   (reset_INV),
      .cs_raw_INV  (bus.req_cs_INV[i]),
      .cs_sync_INV (cs_sync_INV[i]),
      .cs_fall     (cs_fall[i])
    );
  end

  // Simultaneous falls go to whoever did not win last time
  assign pick          = (&cs_fall) ? ~last_owner : cs_fall[REQ_CPU];
  assign owner_release = |(owner & cs_sync_INV);

  always_comb begin
    blk = 2'b00;
    if (state == ARB_GRANT)        blk = cs_fall & ~owner;
    else if (state == ARB_HOLDOFF) blk = cs_fall;
    cnt_sum  = {1'b0, blocked_cnt} + (CNT_W+1)'(blk[0]) + (CNT_W+1)'(blk[1]);
    cnt_next = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

`ifdef SPI_FLASH_ARB_WATCHDOG_EN
  logic [23:0] wdt_cnt;
  logic        wdt_trip;
  logic        wdt_expire;
  assign wdt_expire = (wdt_cnt == WDT_CYCLES - 24'd1);
`else
  logic unused_wdt;
  assign unused_wdt = ^WDT_CYCLES;
`endif

  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      state       <= ARB_IDLE;
      owner       <= 2'b00;
      busy        <= 2'b00;
      blocked_cnt <= '0;
      last_owner  <= 1'b1;
      hold_cnt    <= '0;
`ifdef SPI_FLASH_ARB_WATCHDOG_EN
      wdt_cnt     <= '0;
      wdt_trip    <= 1'b0;
`endif
    end else if (!enable) begin
      state <= ARB_IDLE;
      owner <= 2'b00;
      busy  <= 2'b00;
    end else begin
      blocked_cnt <= cnt_next;
      case (state)
        ARB_IDLE: begin
          if (|cs_fall) begin
            owner      <= req_onehot(pick);
            busy       <= ~req_onehot(pick);
            last_owner <= pick;
            state      <= ARB_GRANT;
`ifdef SPI_FLASH_ARB_WATCHDOG_EN
            wdt_cnt    <= '0;
`endif
          end
        end
        ARB_GRANT: begin
`ifdef SPI_FLASH_ARB_WATCHDOG_EN
          wdt_cnt <= wdt_cnt + 24'd1;
          if (owner_release || wdt_expire) begin
            if (!owner_release) wdt_trip <= 1'b1;
`else
          if (owner_release) begin
`endif
            owner    <= 2'b00;
            busy     <= 2'b11;
            hold_cnt <= HOLD_W'(HOLDOFF_CYCLES - 1);
            state    <= ARB_HOLDOFF;
          end
        end
        ARB_HOLDOFF: begin
          if (hold_cnt == '0) begin
            busy  <= 2'b00;
            state <= ARB_IDLE;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: begin
          state <= ARB_IDLE;
          owner <= 2'b00;
          busy  <= 2'b00;
        end
      endcase
    end
  end

  assign bus.owner        = owner;
  assign bus.busy         = busy;
  assign bus.blocked_cnt  = blocked_cnt;
  assign bus.flash_cs_INV = ~|(owner & ~bus.req_cs_INV);
  assign bus.flash_clk    = |(owner & bus.req_clk);
  assign bus.flash_mosi   = |(owner & bus.req_mosi);
  assign bus.req_miso     = {2{bus.flash_miso}} & owner;
`ifdef SPI_FLASH_ARB_WATCHDOG_EN
  assign bus.wdt_trip     = wdt_trip;
`else
  assign bus.wdt_trip     = 1'b0;
`endif

endmodule
